fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage sitting directly upstream of the `Control` decoder in the lab processor datapath. It holds the program counter, requests instructions from instruction memory over a req/ack handshake, latches each instruction into an instruction register, and presents the 4-bit opcode (`instr[15:12]`) that drives `Control`'s `control_input`. It supports downstream stall and branch redirect.

## Interface
- `ADDR_W`, 8, PC / instruction-memory address width
- `INSTR_W`, 16, instruction width; opcode is always the top 4 bits
- `clk`  in  1  sole clock, all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  ADDR_W  fetch address (equals `pc`)
- `imem_ack`  in  1  memory has valid data on `imem_rdata` this cycle
- `imem_rdata`  in  INSTR_W  instruction word
- `stall`  in  1  downstream cannot accept the current instruction
- `branch_taken`  in  1  redirect fetch this cycle
- `branch_target`  in  ADDR_W  redirect address
- `instr`  out  INSTR_W  instruction register
- `opcode`  out  4  `instr[INSTR_W-1:INSTR_W-4]`, feeds `Control`
- `instr_valid`  out  1  `instr` holds a valid, unconsumed instruction
- `pc`  out  ADDR_W  address of the next instruction to fetch
- `halted`  out  1  fetch stopped (only with `FETCH_HALT_EN`; else tied 0)

## Operation
- Reset (`rst_n`=0 at an edge): state=IDLE, `pc`=0, `instr`=0, `opcode`=0, `instr_valid`=0, `imem_req`=0, `halted`=0. Applies from any state and discards any in-flight request.
- States: IDLE, FETCH, ISSUE, HALT (HALT only with `FETCH_HALT_EN`).
- IDLE: unconditionally -> FETCH on the next edge.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`, both stable until ack. On `imem_ack`=1: `instr`<=`imem_rdata`, `pc`<=`pc`+1, go to ISSUE. On `imem_ack`=0: stay.
- ISSUE: `instr_valid`=1. On `stall`=0 the instruction is consumed this cycle; go to FETCH. On `stall`=1: hold `instr`, `pc` and state.
- `imem_req` = (state==FETCH). `instr_valid` = (state==ISSUE). Both are decoded from the state register, with no input-to-output combinational path.
- Branch: `branch_taken`=1 in FETCH or ISSUE sets `pc`<=`branch_target` and moves to FETCH next cycle. A coincident `imem_ack` is ignored, with `instr` unchanged. A coincident `stall` is ignored. A held instruction is flushed, so `instr_valid`=0 next cycle. Branch has priority over ack and stall. Branch in IDLE or HALT is ignored.
- PC arithmetic: modulo 2^ADDR_W; `pc`=2^ADDR_W-1 increments to 0 with no flag.

## Timing
- Zero-wait memory (ack in the same cycle as req): request in cycle N, `instr_valid`=1 in N+1, next request in N+2. Peak throughput is 1 instruction per 2 cycles.
- Each memory wait cycle adds one cycle of latency.
- `opcode` is valid whenever `instr_valid`=1 and is constant while stalled.
- `pc`, `instr` and `instr_valid` change only at rising edges. `rst_n` is sampled only at edges.

## Configuration
- `FETCH_HALT_EN` defined: when an instruction with opcode 4'hF is consumed in ISSUE (`stall`=0, no branch), go to HALT. In HALT, `halted`=1, `imem_req`=0 and `instr_valid`=0. Only reset exits HALT.
- `FETCH_HALT_EN` undefined: 4'hF is treated as an ordinary opcode, there is no HALT state, and `halted` is constant 0.

## Test plan
- Reset release with zero-wait memory returning `imem_rdata`=16'hA123 at address 0: `imem_req` rises 1 cycle after reset release; `instr_valid`=1 with `opcode`=4'hA one cycle later; `pc`=1; next `imem_addr`=1.
- Memory acks after 3 wait cycles: `imem_addr` is held at 0 for 4 cycles, then `instr` is captured, with no duplicate PC increment.
- `stall`=1 for 5 cycles in ISSUE holding 16'hC0FF: `opcode`=4'hC, `instr` and `pc` are unchanged, `imem_req`=0 throughout; fetch resumes 1 cycle after `stall` drops.
- `branch_taken`=1 with `branch_target`=8'h40 coincident with `imem_ack` and `stall`: the acked data is discarded, next `imem_addr`=8'h40, `instr_valid`=0. `pc`=8'hFF fetch: `pc` wraps to 0.
- Assert `rst_n`=0 mid-FETCH and mid-ISSUE: all outputs return to reset values at the next edge.
- With `FETCH_HALT_EN`, fetch 16'hF000 with `stall`=0: `halted`=1 and no further `imem_req`. Without the macro, fetch continues at `pc`+1.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem req/ack, instruction register, stall and branch redirect
// Optional HALT on opcode 4'hF is enabled by defining FETCH_HALT_EN.
module fetch_stage #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  pc_next;
    logic [INSTR_W-1:0] instr_next;
    logic               redirect;
    logic               is_halt_op;

    assign redirect = branch_taken && (state == FETCH || state == ISSUE);

`ifdef FETCH_HALT_EN
    assign is_halt_op = (instr[INSTR_W-1:INSTR_W-4] == 4'hF);
`else
    assign is_halt_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= '0;
            instr <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            instr <= instr_next;
        end
    end

    // Branch wins over ack and stall; a coincident ack's data is dropped.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instr;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                if (redirect) begin
                    pc_next    = branch_target;
                    state_next = FETCH;
                end else if (imem_ack) begin
                    instr_next = imem_rdata;
                    pc_next    = pc + 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (redirect) begin
                    pc_next    = branch_target;
                    state_next = FETCH;
                end else if (!stall) begin
                    state_next = is_halt_op ? HALT : FETCH;
                end
            end
            HALT: begin
`ifdef FETCH_HALT_EN
                state_next = HALT;
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (state == FETCH);
        instr_valid = (state == ISSUE);
`ifdef FETCH_HALT_EN
        halted      = (state == HALT);
`else
        halted      = 1'b0;
`endif
    end

    assign imem_addr = pc;
    assign opcode    = instr[INSTR_W-1:INSTR_W-4];

endmodule
